// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU. It decodes the instruction, reads the register file with
// writeback forwarding, tracks register hazards and holds one registered operand bundle.
module alu_operand_stage #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned IMM_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [2:0]        op,
  output logic [2:0]        out_rd,
  input  logic              wb_en,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d, out_rd_q, out_rd_d;

  logic [2:0]        f_op, f_rd, f_rs1, f_rs2;
  logic              f_use_imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic [NREGS-1:0]  clr_mask, pend_eff;
  logic              hazard, accept;

  // Instruction field decode.
  always_comb begin
    f_op      = instr[15:13];
    f_rd      = instr[12:10];
    f_rs1     = instr[9:7];
    f_use_imm = instr[6];
    f_rs2     = instr[5:3];
    imm_ext   = DATA_W'(instr[IMM_W-1:0]);
  end

  // Register reads. A same-cycle writeback to a source register wins over the stored value.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (f_rs1 != 3'd0) begin
      rs1_val = (wb_en && wb_rd == f_rs1) ? wb_data : regs_q[f_rs1];
    end
    if (f_rs2 != 3'd0) begin
      rs2_val = (wb_en && wb_rd == f_rs2) ? wb_data : regs_q[f_rs2];
    end
  end

  // Hazard detection. A pending bit that this cycle's writeback clears no longer blocks.
  always_comb begin
    clr_mask = '0;
    if (wb_en) begin
      clr_mask[wb_rd] = 1'b1;
    end
    pend_eff = pending_q & ~clr_mask;
    hazard   = pend_eff[f_rs1]
             | (!f_use_imm && pend_eff[f_rs2])
             | ((f_rd != 3'd0) && pend_eff[f_rd]);
    in_ready = !hazard && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  // Next-state logic for the register file, the scoreboard and the output bundle.
  always_comb begin
    regs_d      = regs_q;
    pending_d   = pend_eff;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_rd_d    = out_rd_q;

    if (wb_en && wb_rd != 3'd0) begin
      regs_d[wb_rd] = wb_data;
    end

    if (accept) begin
      if (f_rd != 3'd0) begin
        pending_d[f_rd] = 1'b1;
      end
      out_valid_d = 1'b1;
      a_d         = rs1_val;
      b_d         = f_use_imm ? imm_ext : rs2_val;
      op_d        = f_op;
      out_rd_d    = f_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    pending_d[0] = 1'b0;
    regs_d[0]    = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_rd_q    <= '0;
    end else begin
      regs_q      <= regs_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage. Expected bundles are queued when the reference
// model accepts an instruction and are compared when the DUT's bundle is observed.
module tb_alu_operand_stage;

  localparam int unsigned DATA_W = 9;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic [2:0]        rd;
  } bundle_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, wb_en;
  logic [15:0]       instr;
  logic [DATA_W-1:0] a, b, wb_data;
  logic [2:0]        op, out_rd, wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] m_regs [8];
  logic [7:0]        m_pend;
  logic              m_ov;
  bundle_t           sb [$];

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .op(op), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] o, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {o, rd, rs1, 1'b0, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] o, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [5:0] imm);
    return {o, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input logic [2:0] r);
    if (r == 3'd0) return '0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic logic m_busy(input logic [2:0] r);
    return m_pend[r] && !(wb_en && wb_rd == r);
  endfunction

  // One clock: drive, check combinational ready and the presented bundle, then update the model.
  task automatic cyc(input logic vld, input logic [15:0] ins, input logic ordy,
                     input logic wen, input logic [2:0] wrd, input logic [DATA_W-1:0] wdat);
    logic    haz, exp_rdy, acc;
    bundle_t e, exp_b;
    in_valid = vld; instr = ins; out_ready = ordy; wb_en = wen; wb_rd = wrd; wb_data = wdat;
    @(negedge clk);
    haz = m_busy(ins[9:7]) || (!ins[6] && m_busy(ins[5:3])) ||
          (ins[12:10] != 3'd0 && m_busy(ins[12:10]));
    exp_rdy = !haz && (!m_ov || ordy);
    acc = vld && exp_rdy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(1), 32'(0));
      end else begin
        e = ordy ? sb.pop_front() : sb[0];
        chk("a", 32'(a), 32'(e.a));
        chk("b", 32'(b), 32'(e.b));
        chk("op", 32'(op), 32'(e.op));
        chk("out_rd", 32'(out_rd), 32'(e.rd));
      end
    end
    if (acc) begin
      exp_b.a  = m_read(ins[9:7]);
      exp_b.b  = ins[6] ? DATA_W'(ins[5:0]) : m_read(ins[5:3]);
      exp_b.op = ins[15:13];
      exp_b.rd = ins[12:10];
      sb.push_back(exp_b);
    end
    @(posedge clk);
    if (wen && wrd != 3'd0) m_regs[wrd] = wdat;
    if (wen) m_pend[wrd] = 1'b0;
    if (acc && ins[12:10] != 3'd0) m_pend[ins[12:10]] = 1'b1;
    if (acc) m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; wb_en = 1'b1; wb_rd = 3'd2;
    wb_data = 9'h1AB; instr = enc_r(3'd0, 3'd1, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_pend = '0;
    m_ov = 1'b0;
    sb.delete();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_a", 32'(a), 32'(0));
    chk("rst_b", 32'(b), 32'(0));
    chk("rst_op", 32'(op), 32'(0));
    chk("rst_out_rd", 32'(out_rd), 32'(0));
  endtask

  localparam logic [15:0] NOP = 16'h0000;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    instr = '0;
    @(posedge clk);
    do_reset();

    // Register writes, then a register-register instruction.
    cyc(1'b0, NOP, 1'b1, 1'b1, 3'd1, 9'h005);
    cyc(1'b0, NOP, 1'b1, 1'b1, 3'd2, 9'h003);
    cyc(1'b1, enc_r(3'd0, 3'd3, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, '0);
    // Immediate with R0 source, then a write to R0 that must not stick.
    cyc(1'b1, enc_i(3'd3, 3'd4, 3'd0, 6'h2A), 1'b1, 1'b0, 3'd0, '0);
    cyc(1'b0, NOP, 1'b1, 1'b1, 3'd0, 9'h1FF);
    cyc(1'b1, enc_r(3'd1, 3'd0, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, '0);
    cyc(1'b0, NOP, 1'b1, 1'b0, 3'd0, '0);

    // RAW stall on R3 until its writeback, which is forwarded into a.
    for (int i = 0; i < 3; i++) cyc(1'b1, enc_r(3'd2, 3'd6, 3'd3, 3'd0), 1'b1, 1'b0, 3'd0, '0);
    cyc(1'b1, enc_r(3'd2, 3'd6, 3'd3, 3'd0), 1'b1, 1'b1, 3'd3, 9'h008);
    cyc(1'b0, NOP, 1'b1, 1'b1, 3'd4, 9'h0F0);
    cyc(1'b0, NOP, 1'b1, 1'b1, 3'd6, 9'h123);

    // Backpressure: the held bundle must stay stable, then accept and drain share a cycle.
    cyc(1'b1, enc_r(3'd4, 3'd7, 3'd1, 3'd6), 1'b0, 1'b0, 3'd0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b1, enc_i(3'd5, 3'd0, 3'd4, 6'h15), 1'b0, 1'b0, 3'd0, '0);
    cyc(1'b1, enc_i(3'd5, 3'd0, 3'd4, 6'h15), 1'b1, 1'b0, 3'd0, '0);
    cyc(1'b0, NOP, 1'b1, 1'b1, 3'd7, 9'h0AA);

    // WAW on R5: stall until writeback; same-cycle clear and set leaves R5 pending.
    cyc(1'b1, enc_r(3'd6, 3'd5, 3'd1, 3'd2), 1'b1, 1'b0, 3'd0, '0);
    for (int i = 0; i < 2; i++) cyc(1'b1, enc_i(3'd7, 3'd5, 3'd2, 6'h3F), 1'b1, 1'b0, 3'd0, '0);
    cyc(1'b1, enc_i(3'd7, 3'd5, 3'd2, 6'h3F), 1'b1, 1'b1, 3'd5, 9'h011);
    for (int i = 0; i < 2; i++) cyc(1'b1, enc_r(3'd0, 3'd0, 3'd5, 3'd0), 1'b1, 1'b0, 3'd0, '0);
    cyc(1'b1, enc_r(3'd0, 3'd0, 3'd5, 3'd5), 1'b1, 1'b1, 3'd5, 9'h1C3);
    cyc(1'b0, NOP, 1'b1, 1'b0, 3'd0, '0);

    // Reset with a bundle pending and scoreboard bits set.
    cyc(1'b1, enc_r(3'd1, 3'd2, 3'd1, 3'd7), 1'b0, 1'b0, 3'd0, '0);
    do_reset();
    cyc(1'b0, NOP, 1'b1, 1'b0, 3'd0, '0);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b1, enc_r(3'd0, 3'd0, 3'(i), 3'(i)), 1'b1, 1'b0, 3'd0, '0);
    end
    cyc(1'b0, NOP, 1'b1, 1'b0, 3'd0, '0);
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
